// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, debounces one key at a
// time on the synchronized rows and emits one hex code per accepted press.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 48000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        row_s1, rs;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        col_q, col_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        pat_q, pat_d;
  logic [3:0]        key_d;
  logic              valid_d, held_d;
  logic              sample_c, single_low_c, all_high_c;

  // Hex code for a single-low row pattern on column c.
  function automatic logic [3:0] key_code(input logic [3:0] pat, input logic [1:0] c);
    logic [1:0] r;
    r        = 2'd0;
    key_code = 4'h0;
    case (pat)
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      4'b0111: r = 2'd3;
      default: r = 2'd0;
    endcase
    case ({r, c})
      4'h0: key_code = 4'h1;
      4'h1: key_code = 4'h2;
      4'h2: key_code = 4'h3;
      4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;
      4'h5: key_code = 4'h5;
      4'h6: key_code = 4'h6;
      4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;
      4'h9: key_code = 4'h8;
      4'hA: key_code = 4'h9;
      4'hB: key_code = 4'hC;
      4'hC: key_code = 4'hE;
      4'hD: key_code = 4'h0;
      4'hE: key_code = 4'hF;
      default: key_code = 4'hD;
    endcase
  endfunction

  assign sample_c     = (slot_q == SLOT_LAST);
  assign all_high_c   = (rs == 4'b1111);
  assign single_low_c = (rs == 4'b1110) || (rs == 4'b1101) ||
                        (rs == 4'b1011) || (rs == 4'b0111);

  // State register, synchronizer and registered outputs.
  always_ff @(posedge int_osc) begin
    if (!reset) begin
      row_s1    <= 4'b1111;
      rs        <= 4'b1111;
      state_q   <= SCAN;
      slot_q    <= '0;
      col_q     <= 2'd0;
      cnt_q     <= '0;
      pat_q     <= 4'b1111;
      cols      <= 4'b1110;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      row_s1    <= rows;
      rs        <= row_s1;
      state_q   <= state_d;
      slot_q    <= slot_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      cols      <= ~(4'b0001 << col_d);
      key       <= key_d;
      key_valid <= valid_d;
      key_held  <= held_d;
    end
  end

  // Next-state logic; every decision is taken only on the last cycle of a slot.
  always_comb begin
    state_d = state_q;
    slot_d  = sample_c ? '0 : slot_q + SLOT_W'(1);
    col_d   = col_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    key_d   = key;
    valid_d = 1'b0;
    held_d  = key_held;

    case (state_q)
      SCAN: begin
        if (sample_c) begin
          if (single_low_c) begin
            pat_d = rs;
            cnt_d = CNT_ONE;
            if (CNT_ONE == CNT_DONE) begin
              state_d = HELD;
              cnt_d   = '0;
              key_d   = key_code(rs, col_q);
              valid_d = 1'b1;
              held_d  = 1'b1;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end

      DEBOUNCE: begin
        if (sample_c) begin
          if (rs == pat_q) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_d == CNT_DONE) begin
              state_d = HELD;
              cnt_d   = '0;
              key_d   = key_code(pat_q, col_q);
              valid_d = 1'b1;
              held_d  = 1'b1;
            end
          end else begin
            state_d = SCAN;
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
          end
        end
      end

      HELD: begin
        if (sample_c && all_high_c) begin
          cnt_d = CNT_ONE;
          if (CNT_ONE == CNT_DONE) begin
            state_d = SCAN;
            cnt_d   = '0;
            held_d  = 1'b0;
            col_d   = col_q + 2'd1;
          end else begin
            state_d = RELEASE;
          end
        end
      end

      RELEASE: begin
        if (sample_c) begin
          if (all_high_c) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_d == CNT_DONE) begin
              state_d = SCAN;
              cnt_d   = '0;
              held_d  = 1'b0;
              col_d   = col_q + 2'd1;
            end
          end else begin
            state_d = HELD;
            cnt_d   = '0;
          end
        end
      end

      default: state_d = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model closes rows onto the driven
// columns; a sample-level reference model predicts every output on every cycle.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 3;
  localparam logic [3:0] KMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                       4'h4, 4'h5, 4'h6, 4'hB,
                                       4'h7, 4'h8, 4'h9, 4'hC,
                                       4'hE, 4'h0, 4'hF, 4'hD};
  localparam logic [3:0] IDLE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic        int_osc = 1'b0;
  logic        reset;
  logic [3:0]  rows, cols, key;
  logic        key_valid, key_held;
  logic [15:0] pressed;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int edge_n = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .int_osc  (int_osc),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .key      (key),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 int_osc = ~int_osc;

  // Key at (r,c) shorts row r to column c; rows are pulled high otherwise.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && (cols[c] == 1'b0)) rows[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int row_of(input logic [3:0] p);
    for (int r = 0; r < 4; r++) if (!p[r]) return r;
    return 0;
  endfunction

  // Reference model: each slot ends in one sample of the rows seen two edges
  // earlier; a press needs DC equal single-key samples on the scanned column,
  // a release needs DC consecutive all-high samples.
  logic [3:0] m_s1, m_s2, m_pat;
  logic [3:0] exp_cols, exp_key;
  logic       exp_valid, exp_held;
  int         m_slot, m_col, m_streak;
  bit         m_held;
  bit         m_ok = 1'b0;

  always @(posedge int_osc) begin
    logic [3:0] rsv;
    if (!reset) begin
      edge_n    = 0;
      m_s1      = 4'hF;
      m_s2      = 4'hF;
      m_pat     = 4'hF;
      m_slot    = 0;
      m_col     = 0;
      m_streak  = 0;
      m_held    = 1'b0;
      exp_cols  = 4'b1110;
      exp_key   = 4'h0;
      exp_valid = 1'b0;
      exp_held  = 1'b0;
      m_ok      = 1'b1;
    end else begin
      edge_n++;
      rsv  = m_s2;
      m_s2 = m_s1;
      m_s1 = rows;
      exp_valid = 1'b0;
      if (m_slot == SD - 1) begin
        if (!m_held) begin
          if (m_streak > 0) begin
            if (rsv == m_pat) m_streak++;
            else begin
              m_streak = 0;
              m_col = (m_col + 1) % 4;
            end
          end else if ($countones(~rsv) == 1) begin
            m_pat = rsv;
            m_streak = 1;
          end else begin
            m_col = (m_col + 1) % 4;
          end
          if (m_streak == DC) begin
            exp_key   = KMAP[row_of(m_pat)*4 + m_col];
            exp_valid = 1'b1;
            m_held    = 1'b1;
            m_streak  = 0;
          end
        end else begin
          if (rsv == 4'hF) m_streak++;
          else m_streak = 0;
          if (m_streak == DC) begin
            m_held   = 1'b0;
            m_streak = 0;
            m_col    = (m_col + 1) % 4;
          end
        end
      end
      m_slot   = (m_slot + 1) % SD;
      exp_held = m_held;
      exp_cols = ~(4'b0001 << m_col);
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge int_osc) begin
    if (m_ok) begin
      check("cols", 32'(cols), 32'(exp_cols));
      check("key", 32'(key), 32'(exp_key));
      check("key_valid", 32'(key_valid), 32'(exp_valid));
      check("key_held", 32'(key_held), 32'(exp_held));
      if (key_valid === 1'b1) pulses++;
    end
  end

  task automatic do_reset(input int n);
    @(negedge int_osc);
    reset = 1'b0;
    repeat (n) @(negedge int_osc);
    reset = 1'b1;
    pulses = 0;
  endtask

  initial begin
    int first;
    int kind;
    reset   = 1'b0;
    pressed = '0;

    // Idle scan
    do_reset(2);
    for (int i = 1; i <= 16; i++) begin
      @(negedge int_osc);
      if (i % 4 == 0) check($sformatf("idle_cols_%0d", i), 32'(cols), 32'(IDLE[(i/4)%4]));
    end
    check("idle_pulses", 32'(pulses), 32'd0);

    // Single press of "5"
    pressed = '0; pressed[5] = 1'b1;
    do_reset(2);
    first = -1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge int_osc);
      if (key_valid === 1'b1 && first < 0) begin
        first = i;
        check("s2_key", 32'(key), 32'h5);
        check("s2_held", 32'(key_held), 32'd1);
      end
    end
    check("s2_valid_cycle", 32'(first), 32'd16);
    check("s2_pulses", 32'(pulses), 32'd1);
    check("s2_cols", 32'(cols), 32'(4'b1101));
    pressed = '0;
    repeat (30) @(negedge int_osc);

    // Bounce during debounce of "9"
    pressed = '0; pressed[10] = 1'b1;
    do_reset(2);
    first = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge int_osc);
      if (key_valid === 1'b1 && first < 0) first = i;
      if (i == 13) pressed[10] = 1'b0;
      if (i == 14) pressed[10] = 1'b1;
    end
    check("s3_valid_cycle", 32'(first), 32'd40);
    check("s3_pulses", 32'(pulses), 32'd1);
    check("s3_key", 32'(key), 32'h9);
    pressed = '0;
    repeat (30) @(negedge int_osc);

    // Release bounce on "D"
    pressed = '0; pressed[15] = 1'b1;
    do_reset(2);
    for (int i = 1; i <= 50; i++) begin
      @(negedge int_osc);
      if (i == 24) check("s4_valid", 32'(key_valid), 32'd1);
      if (i == 40) check("s4_held_bounce", 32'(key_held), 32'd1);
      if (i == 43) check("s4_held_late", 32'(key_held), 32'd1);
      if (i == 44) begin
        check("s4_released", 32'(key_held), 32'd0);
        check("s4_cols_col0", 32'(cols), 32'(4'b1110));
      end
      if (i == 24 || i == 32) pressed[15] = 1'b0;
      if (i == 28) pressed[15] = 1'b1;
    end
    check("s4_pulses", 32'(pulses), 32'd1);
    check("s4_key", 32'(key), 32'hD);

    // Two keys on one column: never accepted
    pressed = '0; pressed[0] = 1'b1; pressed[4] = 1'b1;
    do_reset(2);
    for (int i = 1; i <= 40; i++) begin
      @(negedge int_osc);
      if (i == 4) check("s5_cols_advance", 32'(cols), 32'(4'b1101));
    end
    check("s5_multi_pulses", 32'(pulses), 32'd0);

    // "1" held, then "4" added
    pressed = '0; pressed[0] = 1'b1;
    do_reset(2);
    for (int i = 1; i <= 40; i++) begin
      @(negedge int_osc);
      if (i == 14) pressed[4] = 1'b1;
    end
    check("s5_pulses", 32'(pulses), 32'd1);
    check("s5_key", 32'(key), 32'h1);
    check("s5_held", 32'(key_held), 32'd1);

    // Reset while "A" is held
    pressed = '0; pressed[3] = 1'b1;
    do_reset(2);
    repeat (26) @(negedge int_osc);
    check("s6_held_before", 32'(key_held), 32'd1);
    check("s6_key_before", 32'(key), 32'hA);
    reset = 1'b0;
    @(negedge int_osc);
    check("s6_rst_cols", 32'(cols), 32'(4'b1110));
    check("s6_rst_key", 32'(key), 32'h0);
    check("s6_rst_held", 32'(key_held), 32'd0);
    check("s6_rst_valid", 32'(key_valid), 32'd0);
    reset = 1'b1;
    pulses = 0;
    repeat (40) @(negedge int_osc);
    check("s6_again_pulses", 32'(pulses), 32'd1);
    check("s6_again_key", 32'(key), 32'hA);

    // Randomized presses, releases, multi-key, glitches and resets
    for (int t = 0; t < 200; t++) begin
      kind = int'($urandom_range(0, 19));
      if (kind == 0) do_reset(int'($urandom_range(1, 3)));
      else if (kind < 7) pressed = '0;
      else if (kind < 16) begin
        pressed = '0;
        pressed[$urandom_range(0, 15)] = 1'b1;
      end else pressed = pressed | (16'h1 << $urandom_range(0, 15));
      repeat ($urandom_range(1, 60)) @(negedge int_osc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
